// File: rtl/lcd_pkg.sv
// Shared constants and state encodings for the HD44780 character LCD driver.
package lcd_pkg;

   localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
   localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
   localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
   localparam logic [7:0] CMD_CLEAR     = 8'h01;
   localparam logic [7:0] CMD_LINE1     = 8'h80;
   localparam logic [7:0] CMD_LINE2     = 8'hC0;

   localparam logic [5:0] INIT_LAST  = 6'd3;
   localparam logic [5:0] FRAME_LAST = 6'd33;
   localparam logic [5:0] LINE2_STEP = 6'd17;

   typedef enum logic [1:0] {
      ST_POWERUP,
      ST_INIT,
      ST_FRAME,
      ST_GAP
   } state_t;

   typedef enum logic [1:0] {
      X_IDLE,
      X_SETUP,
      X_EHIGH,
      X_HOLD
   } xstate_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      logic [7:0] c;
      case (idx)
         2'd0:    c = CMD_FUNC_8B2L;
         2'd1:    c = CMD_DISP_ON;
         2'd2:    c = CMD_ENTRY_INC;
         default: c = CMD_CLEAR;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/lcd_xfer.sv
// Single LCD bus transfer: SETUP -> E_HIGH -> HOLD, with a one-cycle done pulse.
module lcd_xfer
   import lcd_pkg::*;
#(
   parameter int SETUP_CYCLES   = 2,
   parameter int E_PULSE_CYCLES = 12,
   parameter int CMD_CYCLES     = 2000,
   parameter int CLEAR_CYCLES   = 82000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       rs,
   input  logic [7:0] data,
   input  logic       long_wait,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic [7:0] lcd_data,
   output logic       done
);

   localparam int MAXC = max2(max2(SETUP_CYCLES, E_PULSE_CYCLES),
                              max2(CMD_CYCLES, CLEAR_CYCLES));
   localparam int CW = $clog2(MAXC + 1);

   localparam logic [CW-1:0] LOAD_AT    = CW'(SETUP_CYCLES - 2);
   localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] E_LAST     = CW'(E_PULSE_CYCLES - 1);
   localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_CYCLES - 1);
   localparam logic [CW-1:0] CLR_LAST   = CW'(CLEAR_CYCLES - 1);

   xstate_t       st, st_d;
   logic [CW-1:0] cnt, cnt_d;
   logic          long_q, long_d;
   logic          e_d, rs_d, done_d;
   logic [7:0]    data_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= X_IDLE;
         cnt      <= '0;
         long_q   <= 1'b0;
         lcd_e    <= 1'b0;
         lcd_rs   <= 1'b0;
         lcd_data <= 8'h00;
         done     <= 1'b0;
      end else begin
         st       <= st_d;
         cnt      <= cnt_d;
         long_q   <= long_d;
         lcd_e    <= e_d;
         lcd_rs   <= rs_d;
         lcd_data <= data_d;
         done     <= done_d;
      end
   end

   always_comb begin
      st_d   = st;
      cnt_d  = cnt;
      long_d = long_q;
      e_d    = lcd_e;
      rs_d   = lcd_rs;
      data_d = lcd_data;
      done_d = 1'b0;
      unique case (st)
         X_IDLE: begin
            if (start) begin
               st_d   = X_SETUP;
               cnt_d  = '0;
               rs_d   = rs;
               long_d = long_wait;
            end
         end
         X_SETUP: begin
            cnt_d = cnt + 1'b1;
            // data is captured one cycle late so bus has settled after addr moved
            if (cnt == LOAD_AT) data_d = data;
            if (cnt == SETUP_LAST) begin
               st_d  = X_EHIGH;
               cnt_d = '0;
               e_d   = 1'b1;
            end
         end
         X_EHIGH: begin
            cnt_d = cnt + 1'b1;
            if (cnt == E_LAST) begin
               st_d  = X_HOLD;
               cnt_d = '0;
               e_d   = 1'b0;
            end
         end
         X_HOLD: begin
            cnt_d = cnt + 1'b1;
            if (cnt == (long_q ? CLR_LAST : CMD_LAST)) begin
               st_d   = X_IDLE;
               cnt_d  = '0;
               done_d = 1'b1;
            end
         end
      endcase
   end

endmodule

// File: rtl/lcd_driver.sv
// HD44780 16x2 driver: power-up wait, init commands, then continuous redraw
module lcd_driver
   import lcd_pkg::*;
#(
   parameter int POWERUP_CYCLES = 750000,
   parameter int SETUP_CYCLES   = 2,
   parameter int E_PULSE_CYCLES = 12,
   parameter int CMD_CYCLES     = 2000,
   parameter int CLEAR_CYCLES   = 82000,
   parameter int REFRESH_CYCLES = 500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       refresh,
   output logic [4:0] addr,
   input  logic [7:0] bus,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_data,
   output logic       init_done,
   output logic       busy
);

   localparam int TOP_MAX = max2(POWERUP_CYCLES, REFRESH_CYCLES);
   localparam int TW = $clog2(TOP_MAX + 1);

   localparam logic [TW-1:0] PU_LAST  = TW'(POWERUP_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LAST = TW'(REFRESH_CYCLES - 1);

   state_t        st, st_d;
   logic [TW-1:0] cnt, cnt_d;
   logic [5:0]    step, step_d;
   logic          inflight, inflight_d;
   logic          pend, pend_d;
   logic          init_done_d, busy_d;
   logic [4:0]    addr_d;
   logic          cur_char, cur_char_d;
   logic [7:0]    cur_cmd, cur_cmd_d;

   logic          start, start_rs, start_long;
   logic          f_char;
   logic [7:0]    f_cmd;
   logic [4:0]    f_addr;
   logic [7:0]    x_data;
   logic          x_done;

   assign x_data = cur_char ? bus : cur_cmd;

   lcd_xfer #(
      .SETUP_CYCLES   (SETUP_CYCLES),
      .E_PULSE_CYCLES (E_PULSE_CYCLES),
      .CMD_CYCLES     (CMD_CYCLES),
      .CLEAR_CYCLES   (CLEAR_CYCLES)
   ) u_xfer (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .rs        (start_rs),
      .data      (x_data),
      .long_wait (start_long),
      .lcd_e     (lcd_e),
      .lcd_rs    (lcd_rs),
      .lcd_data  (lcd_data),
      .done      (x_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= ST_POWERUP;
         cnt       <= '0;
         step      <= '0;
         inflight  <= 1'b0;
         pend      <= 1'b0;
         init_done <= 1'b0;
         busy      <= 1'b1;
         addr      <= '0;
         cur_char  <= 1'b0;
         cur_cmd   <= 8'h00;
         lcd_rw    <= 1'b0;
      end else begin
         st        <= st_d;
         cnt       <= cnt_d;
         step      <= step_d;
         inflight  <= inflight_d;
         pend      <= pend_d;
         init_done <= init_done_d;
         busy      <= busy_d;
         addr      <= addr_d;
         cur_char  <= cur_char_d;
         cur_cmd   <= cur_cmd_d;
         lcd_rw    <= 1'b0;
      end
   end

   // frame step 0: line-1 cmd, 1..16: chars 0..15, 17: line-2 cmd, 18..33: chars 16..31
   always_comb begin
      f_char = 1'b0;
      f_cmd  = CMD_LINE1;
      f_addr = addr;
      unique case (1'b1)
         (step == 6'd0): f_cmd = CMD_LINE1;
         (step == LINE2_STEP): f_cmd = CMD_LINE2;
         (step inside {[6'd1:6'd16]}): begin
            f_char = 1'b1;
            f_addr = 5'(step - 6'd1);
         end
         default: begin
            f_char = 1'b1;
            f_addr = 5'(step - 6'd2);
         end
      endcase
   end

   always_comb begin
      st_d        = st;
      cnt_d       = cnt;
      step_d      = step;
      inflight_d  = inflight;
      pend_d      = pend | refresh;
      init_done_d = init_done;
      busy_d      = busy;
      addr_d      = addr;
      cur_char_d  = cur_char;
      cur_cmd_d   = cur_cmd;
      start       = 1'b0;
      start_rs    = 1'b0;
      start_long  = 1'b0;
      unique case (st)
         ST_POWERUP: begin
            cnt_d = cnt + 1'b1;
            if (cnt == PU_LAST) begin
               st_d   = ST_INIT;
               cnt_d  = '0;
               step_d = '0;
            end
         end
         ST_INIT: begin
            if (!inflight) begin
               start      = 1'b1;
               start_long = (init_cmd(step[1:0]) == CMD_CLEAR);
               inflight_d = 1'b1;
               cur_char_d = 1'b0;
               cur_cmd_d  = init_cmd(step[1:0]);
            end else if (x_done) begin
               inflight_d = 1'b0;
               if (step == INIT_LAST) begin
                  st_d        = ST_FRAME;
                  step_d      = '0;
                  init_done_d = 1'b1;
               end else begin
                  step_d = step + 1'b1;
               end
            end
         end
         ST_FRAME: begin
            if (!inflight) begin
               start      = 1'b1;
               start_rs   = f_char;
               inflight_d = 1'b1;
               cur_char_d = f_char;
               cur_cmd_d  = f_cmd;
               if (f_char) addr_d = f_addr;
            end else if (x_done) begin
               inflight_d = 1'b0;
               if (step == FRAME_LAST) begin
                  st_d   = ST_GAP;
                  step_d = '0;
                  cnt_d  = '0;
                  busy_d = 1'b0;
               end else begin
                  step_d = step + 1'b1;
               end
            end
         end
         ST_GAP: begin
            cnt_d = cnt + 1'b1;
            if (pend || refresh || cnt == GAP_LAST) begin
               st_d   = ST_FRAME;
               cnt_d  = '0;
               pend_d = 1'b0;
               busy_d = 1'b1;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_lcd_driver.sv
// Directed + randomized bench for lcd_driver with a frame-level reference model.
module tb_lcd_driver;

   logic       clk;
   logic       rst_n;
   logic       refresh;
   logic [4:0] addr;
   logic [7:0] bus;
   logic       lcd_e;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [7:0] lcd_data;
   logic       init_done;
   logic       busy;

   logic [7:0] mem [32];
   assign bus = mem[addr];

   lcd_driver #(
      .POWERUP_CYCLES (100),
      .SETUP_CYCLES   (2),
      .E_PULSE_CYCLES (4),
      .CMD_CYCLES     (10),
      .CLEAR_CYCLES   (50),
      .REFRESH_CYCLES (200)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .refresh   (refresh),
      .addr      (addr),
      .bus       (bus),
      .lcd_e     (lcd_e),
      .lcd_rs    (lcd_rs),
      .lcd_rw    (lcd_rw),
      .lcd_data  (lcd_data),
      .init_done (init_done),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         rise;
      int         fall;
      logic       idone;
   } pulse_t;

   pulse_t pq[$];
   int     cyc;
   int     checks;
   int     failures;
   int     rel;

   task automatic check(input logic [31:0] obs, input logic [31:0] exp,
                        input string tag);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // pulse monitor: records every E pulse and checks its timing envelope
   initial begin
      logic       prev_e, rs_h1, rs_h2, p_rs;
      logic [7:0] data_h1, p_data;
      int         width;
      prev_e = 0; rs_h1 = 0; rs_h2 = 0; data_h1 = 0;
      p_rs = 0; p_data = 0; width = 0; cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            prev_e = 0; rs_h1 = 0; rs_h2 = 0; data_h1 = 0; width = 0;
         end else begin
            if (lcd_e && !prev_e) begin
               check(rs_h2, lcd_rs, "rs_setup_2");
               check(rs_h1, lcd_rs, "rs_setup_1");
               check(data_h1, lcd_data, "data_setup");
               if (lcd_rs) check(lcd_data, mem[addr], "char_vs_bus");
               pq.push_back('{rs: lcd_rs, data: lcd_data, rise: cyc,
                              fall: 0, idone: init_done});
               p_rs = lcd_rs;
               p_data = lcd_data;
               width = 1;
            end else if (lcd_e) begin
               width++;
               check(lcd_rs, p_rs, "rs_hold_in_e");
               check(lcd_data, p_data, "data_hold_in_e");
            end else if (prev_e) begin
               check(width, 4, "e_width");
               pq[pq.size()-1].fall = cyc;
            end
            check(lcd_rw, 0, "rw_zero");
            rs_h2 = rs_h1;
            rs_h1 = lcd_rs;
            data_h1 = lcd_data;
            prev_e = lcd_e;
         end
      end
   end

   task automatic wait_pulses(input int n, input int budget, input string tag);
      int k;
      k = 0;
      while (pq.size() < n && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      if (pq.size() < n) check(0, 1, {"timeout_", tag});
   endtask

   task automatic wait_busy(input logic v, input int budget, input string tag);
      int k;
      k = 0;
      while (busy !== v && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      if (busy !== v) check(0, 1, {"timeout_", tag});
   endtask

   task automatic check_frame(input int s, input string tag);
      logic [8:0] exp [34];
      exp[0] = {1'b0, 8'h80};
      exp[17] = {1'b0, 8'hC0};
      for (int i = 0; i < 16; i++) begin
         exp[1 + i]  = {1'b1, mem[i]};
         exp[18 + i] = {1'b1, mem[16 + i]};
      end
      check(pq.size(), s + 34, {tag, "_count"});
      for (int k = 0; k < 34; k++)
         if (s + k < pq.size())
            check({pq[s+k].rs, pq[s+k].data}, exp[k],
                  $sformatf("%s_%0d", tag, k));
   endtask

   task automatic check_boot(input string tag);
      int b;
      logic [7:0] icmd [4];
      icmd[0] = 8'h38; icmd[1] = 8'h0C; icmd[2] = 8'h06; icmd[3] = 8'h01;
      b = pq.size();
      wait_pulses(b + 1, 400, {tag, "_first"});
      if (pq.size() > b) begin
         check((pq[b].rise - rel) >= 100, 1, {tag, "_powerup_wait"});
         check(pq[b].idone, 0, {tag, "_init_done_low"});
      end
      wait_pulses(b + 5, 800, {tag, "_init"});
      if (pq.size() >= b + 5) begin
         for (int i = 0; i < 4; i++)
            check({pq[b+i].rs, pq[b+i].data}, {1'b0, icmd[i]},
                  $sformatf("%s_init_%0d", tag, i));
         check((pq[b+4].rise - pq[b+3].fall) >= 50, 1, {tag, "_clear_wait"});
         check(pq[b+4].idone, 1, {tag, "_init_done_before_80"});
      end
      wait_busy(1'b0, 3000, {tag, "_frame"});
      check_frame(b + 4, {tag, "_frame"});
      check(addr, 31, {tag, "_addr_hold"});
      check(init_done, 1, {tag, "_init_done"});
   endtask

   initial begin
      int b;
      checks = 0;
      failures = 0;
      refresh = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) mem[i] = 8'(8'h41 + i);
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check(lcd_e, 0, "rst_e");
      check(lcd_rs, 0, "rst_rs");
      check(lcd_rw, 0, "rst_rw");
      check(lcd_data, 8'h00, "rst_data");
      check(addr, 0, "rst_addr");
      check(init_done, 0, "rst_init_done");
      check(busy, 1, "rst_busy");
      rst_n = 1'b1;
      rel = cyc;

      check_boot("boot");

      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      @(negedge clk); #1;
      refresh = 1'b1;
      @(negedge clk); #1;
      refresh = 1'b0;
      check(busy, 1, "gap_refresh_start");
      b = pq.size();
      wait_busy(1'b0, 3000, "rand_frame");
      check_frame(b, "rand_frame");

      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      wait_busy(1'b1, 400, "auto_refresh");
      b = pq.size();
      wait_pulses(b + 7, 400, "char5");
      refresh = 1'b1;
      @(negedge clk); #1;
      refresh = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      refresh = 1'b1;
      @(negedge clk); #1;
      refresh = 1'b0;
      wait_busy(1'b0, 3000, "pend_frame");
      check_frame(b, "pend_frame");
      check(addr, 31, "pend_addr_hold");
      @(negedge clk); #1;
      check(busy, 1, "one_gap_cycle");
      wait_busy(1'b0, 3000, "extra_frame");
      check_frame(b + 34, "extra_frame");
      repeat (60) @(negedge clk);
      #1;
      check(busy, 0, "no_second_extra");
      check(pq.size(), b + 68, "no_more_pulses");

      begin
         int k;
         k = 0;
         while (lcd_e !== 1'b1 && k < 400) begin
            @(negedge clk); #1;
            k++;
         end
         if (lcd_e !== 1'b1) check(0, 1, "timeout_e_high");
      end
      rst_n = 1'b0;
      #1;
      check(lcd_e, 0, "midrst_e");
      check(init_done, 0, "midrst_init_done");
      check(addr, 0, "midrst_addr");
      check(busy, 1, "midrst_busy");
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      rel = cyc;
      check_boot("reboot");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
